// File: rtl/count_extender_if.sv
// Snapshot handshake between count_extender and its consumer.
// The slave side is the extender; the master side requests and accepts snapshots.
interface count_extender_if #(
    parameter int W = 16
) ();
    logic         Capture;
    logic         Ready;
    logic [W-1:0] Value;
    logic         Valid;

    modport master (output Capture, output Ready, input Value, input Valid);
    modport slave  (input Capture, input Ready, output Value, output Valid);
endinterface

// File: rtl/count_extender.sv
// Extends the free-running 4-bit counter output with a wrap count, checks +1 sequencing,
// and presents captured snapshots over a Valid/Ready handshake.
module count_extender #(
    parameter  int EXT_W = 12,
    localparam int W     = 4 + EXT_W
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [3:0]           Count,
    input  logic [W-1:0]         Match_Val,
    count_extender_if.slave      snap,
    output logic                 Match,
    output logic                 Seq_Err,
    output logic                 Miss,
    output logic                 Overflow
);
    typedef enum logic [1:0] {SYNC, RUN, HOLD} state_t;

    state_t           state;
    logic [3:0]       lo;
    logic [EXT_W-1:0] upper;
    logic [EXT_W-1:0] upper_next;
    logic             carry;
    logic             seq_ok;
    logic [W-1:0]     ext_x;
    logic [W-1:0]     value;
    logic             valid;

    assign snap.Value = value;
    assign snap.Valid = valid;

    // A wrap is only credited when the step itself is in sequence.
    always_comb begin
        seq_ok              = (Count == lo + 4'd1);
        upper_next          = upper;
        carry               = 1'b0;
        if (seq_ok && lo == 4'hF && Count == 4'h0)
            {carry, upper_next} = {1'b0, upper} + (EXT_W + 1)'(1);
        ext_x               = {upper_next, Count};
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= SYNC;
            lo       <= '0;
            upper    <= '0;
            value    <= '0;
            valid    <= 1'b0;
            Match    <= 1'b0;
            Seq_Err  <= 1'b0;
            Miss     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    lo    <= Count;
                    upper <= '0;
                    Match <= 1'b0;
                    state <= RUN;
                end
                default: begin
                    lo    <= Count;
                    upper <= upper_next;
                    Match <= (ext_x == Match_Val);
                    if (!seq_ok)
                        Seq_Err <= 1'b1;
                    if (carry)
                        Overflow <= 1'b1;
                    if (state == RUN) begin
                        if (snap.Capture) begin
                            value <= ext_x;
                            valid <= 1'b1;
                            state <= HOLD;
                        end
                    end else if (snap.Ready) begin
                        if (snap.Capture) begin
                            value <= ext_x;
                        end else begin
                            valid <= 1'b0;
                            state <= RUN;
                        end
                    end else if (snap.Capture) begin
                        Miss <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
